// File: rtl/counter_ctrl.sv
// counter_ctrl: start/stop/pause controlled up-counter with a latched terminal
// count, one-shot or auto-reload operation and a registered done pulse.
// Control priority within a cycle: rst > stop > pause > terminal count > increment.
// There is no valid/ready handshake here: start, stop and pause are plain
// level-sampled controls evaluated at every rising clock edge.
module counter_ctrl #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic         pause,
    input  logic         mode,
    input  logic [N-1:0] tc_val,
    output logic [N-1:0] q,
    output logic         busy,
    output logic         done,
    output logic [1:0]   state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_e;

    localparam logic [N-1:0] ZERO = '0;
    localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

    state_e       state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic [N-1:0] tc_q, tc_d;
    logic         mode_q, mode_d;
    logic         done_q, done_d;

    // State and datapath registers; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= ZERO;
            tc_q    <= ZERO;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath logic; stop overrides every state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tc_d    = tc_q;
        mode_d  = mode_q;
        done_d  = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
            cnt_d   = ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // tc_val and mode are only captured here, so changes
                    // while busy have no effect on the running sequence.
                    if (start) begin
                        state_d = ST_RUN;
                        cnt_d   = ZERO;
                        tc_d    = tc_val;
                        mode_d  = mode;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else if (cnt_q == tc_q) begin
                        // Wrap at the terminal count, never by overflow.
                        cnt_d   = ZERO;
                        done_d  = 1'b1;
                        state_d = mode_q ? ST_RUN : ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                ST_PAUSE: begin
                    // Leaving pause costs one held cycle before counting resumes.
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = ZERO;
                end
            endcase
        end
    end

    assign q     = cnt_q;
    assign done  = done_q;
    assign state = state_q;
    assign busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl (N=4) with hand-computed expected sequences.
module tb_counter_ctrl;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic         stop;
  logic         pause;
  logic         mode;
  logic [N-1:0] tc_val;
  logic [N-1:0] q;
  logic         busy;
  logic         done;
  logic [1:0]   state;

  int n_checks;
  int n_errors;

  // expected q / done per cycle, consumed by run_expect
  logic [N-1:0] exp_q[$];
  logic         exp_done_q[$];

  counter_ctrl #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .pause  (pause),
    .mode   (mode),
    .tc_val (tc_val),
    .q      (q),
    .busy   (busy),
    .done   (done),
    .state  (state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [N-1:0] eq, input logic ed,
                           input logic [1:0] est);
    check({tag, ".q"},     32'(q),     32'(eq));
    check({tag, ".done"},  32'(done),  32'(ed));
    check({tag, ".state"}, 32'(state), 32'(est));
    check({tag, ".busy"},  32'(busy),  32'(est == 2'b01 || est == 2'b10));
  endtask

  task automatic start_run(input logic [N-1:0] tc, input logic m);
    tc_val = tc;
    mode   = m;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  // step while popping expected q/done; state is given for the whole run
  task automatic run_expect(input string tag, input logic [1:0] est);
    while (exp_q.size() > 0) begin
      step();
      check_out(tag, exp_q.pop_front(), exp_done_q.pop_front(), est);
    end
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 1'b0; tc_val = '0;
    step();
    step();
    check_out("reset", 4'd0, 1'b0, 2'b00);
    rst = 1'b0;
    step();
    check_out("idle_hold", 4'd0, 1'b0, 2'b00);

    // one-shot tc=3: 0,1,2,3,0(done) then IDLE
    start_run(4'd3, 1'b0);
    check_out("os_start", 4'd0, 1'b0, 2'b01);
    exp_q = '{4'd1, 4'd2, 4'd3}; exp_done_q = '{1'b0, 1'b0, 1'b0};
    run_expect("os_cnt", 2'b01);
    step();
    check_out("os_tc", 4'd0, 1'b1, 2'b00);
    step();
    check_out("os_after", 4'd0, 1'b0, 2'b00);

    // auto-reload tc=2: done every third cycle, busy throughout
    start_run(4'd2, 1'b1);
    check_out("ar_start", 4'd0, 1'b0, 2'b01);
    exp_q      = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0, 4'd1};
    exp_done_q = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    run_expect("ar_cnt", 2'b01);
    do_stop();
    check_out("ar_stop", 4'd0, 1'b0, 2'b00);

    // pause tc=5 at q=2 for 3 cycles: 2 held 4 cycles, then 3,4,5,0(done)
    start_run(4'd5, 1'b0);
    exp_q = '{4'd1, 4'd2}; exp_done_q = '{1'b0, 1'b0};
    run_expect("pz_pre", 2'b01);
    pause = 1'b1;
    exp_q = '{4'd2, 4'd2, 4'd2}; exp_done_q = '{1'b0, 1'b0, 1'b0};
    run_expect("pz_hold", 2'b10);
    pause = 1'b0;
    step();
    check_out("pz_resume", 4'd2, 1'b0, 2'b01);
    exp_q = '{4'd3, 4'd4, 4'd5}; exp_done_q = '{1'b0, 1'b0, 1'b0};
    run_expect("pz_post", 2'b01);
    step();
    check_out("pz_tc", 4'd0, 1'b1, 2'b00);

    // stop at q=4 with tc=4: stop beats terminal count, no done
    start_run(4'd4, 1'b1);
    exp_q = '{4'd1, 4'd2, 4'd3, 4'd4}; exp_done_q = '{1'b0, 1'b0, 1'b0, 1'b0};
    run_expect("st_cnt", 2'b01);
    do_stop();
    check_out("st_mid", 4'd0, 1'b0, 2'b00);

    // same with reset mid-run
    start_run(4'd4, 1'b1);
    exp_q = '{4'd1, 4'd2, 4'd3, 4'd4}; exp_done_q = '{1'b0, 1'b0, 1'b0, 1'b0};
    run_expect("rs_cnt", 2'b01);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_out("rs_mid", 4'd0, 1'b0, 2'b00);

    // reset while paused
    start_run(4'd9, 1'b0);
    step();
    pause = 1'b1;
    step();
    check_out("rp_paused", 4'd1, 1'b0, 2'b10);
    rst = 1'b1;
    step();
    rst = 1'b0; pause = 1'b0;
    check_out("rp_reset", 4'd0, 1'b0, 2'b00);

    // start and stop together in IDLE: stop wins
    start = 1'b1; stop = 1'b1; tc_val = 4'd3;
    step();
    start = 1'b0; stop = 1'b0;
    check_out("ss_idle", 4'd0, 1'b0, 2'b00);

    // tc=0 auto-reload: done every cycle, q stays 0
    start_run(4'd0, 1'b1);
    check_out("z_start", 4'd0, 1'b0, 2'b01);
    exp_q = '{4'd0, 4'd0, 4'd0, 4'd0}; exp_done_q = '{1'b1, 1'b1, 1'b1, 1'b1};
    run_expect("z_run", 2'b01);
    do_stop();
    check_out("z_stop", 4'd0, 1'b0, 2'b00);

    // tc=15 one-shot: full range, then wrap with done
    start_run(4'd15, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      exp_q.push_back(4'(i));
      exp_done_q.push_back(1'b0);
    end
    run_expect("full_cnt", 2'b01);
    step();
    check_out("full_tc", 4'd0, 1'b1, 2'b00);

    // start/tc_val/mode changed while busy are ignored
    start_run(4'd3, 1'b1);
    start = 1'b1; tc_val = 4'd1; mode = 1'b0;
    exp_q      = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    exp_done_q = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    run_expect("ign_run", 2'b01);
    start = 1'b0;
    do_stop();
    check_out("ign_stop", 4'd0, 1'b0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 SHALL have parameter: N, 4, counter width in bits (N >= 2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  begin counting; sampled only in IDLE.
REQ-005 SHALL have port: stop  input  1  abort to IDLE from any state.
REQ-006 SHALL have port: pause  input  1  level; hold count while high.
REQ-007 SHALL have port: mode  input  1  0 = one-shot, 1 = auto-reload; latched at start.
REQ-008 SHALL have port: tc_val  input  N  terminal count; latched at start.
REQ-009 SHALL have port: q  output  N  current count (registered).
REQ-010 SHALL have port: busy  output  1  high in RUN or PAUSE.
REQ-011 SHALL have port: done  output  1  one-cycle pulse on terminal count (registered).
REQ-012 SHALL have port: state  output  2  FSM state: IDLE=00, RUN=01, PAUSE=10; 11 unused.

Function
REQ-013 SHALL implement a 3-state FSM (IDLE, RUN, PAUSE) with registered q, done, internal tc_reg[N-1:0] and mode_reg.
REQ-014 SHALL apply per-cycle priority: rst > stop > pause > terminal count > increment.
REQ-015 IDLE: q holds; start=1 and stop=0 -> q<=0, tc_reg<=tc_val, mode_reg<=mode, next RUN.
REQ-016 RUN, q != tc_reg, pause=0: q<=q+1, stay RUN.
REQ-017 RUN, q == tc_reg, pause=0: q<=0, done<=1 next cycle; mode_reg=1 -> stay RUN; mode_reg=0 -> IDLE.
REQ-018 RUN or PAUSE, pause=1 (stop=0): q holds, next PAUSE; terminal count not evaluated.
REQ-019 PAUSE, pause=0 (stop=0): q holds this cycle, next RUN; counting resumes the following cycle.
REQ-020 stop=1 in any state: q<=0, done<=0, next IDLE.
REQ-021 done SHALL be high only in the cycle after a REQ-017 transition; otherwise 0.
REQ-022 start SHALL be ignored in RUN and PAUSE; tc_val and mode changes SHALL be ignored while busy.
REQ-023 Counting SHALL never exceed tc_reg; q wraps to 0 at tc_reg, never via modulo-2^N overflow.
REQ-024 tc_val=0: terminal count on the first RUN cycle; auto-reload -> done every cycle, q stays 0.
REQ-025 tc_val=2^N-1: full-range count, q reaches all-ones and then returns to 0 per REQ-017.
REQ-026 start and stop both high in IDLE: stop wins, stay IDLE.
REQ-027 busy SHALL be combinational from state (state==RUN or PAUSE).
REQ-028 Period in auto-reload without pause SHALL be tc_reg+1 cycles between done pulses.

Reset
REQ-029 rst=1 at posedge SHALL force state=IDLE, q=0, done=0, busy=0, tc_reg=0, mode_reg=0.
REQ-030 rst SHALL override all inputs, including a mid-RUN or mid-PAUSE reset.
REQ-031 No asynchronous reset path SHALL exist.

Verification
REQ-032 One-shot: tc_val=3, mode=0, start 1 cycle -> q 0,1,2,3,0; done high 1 cycle with q=0; state back to IDLE.
REQ-033 Auto-reload: tc_val=2, mode=1 -> q 0,1,2,0,1,2...; done every 3 cycles; busy stays 1.
REQ-034 Pause: tc_val=5, pause high 3 cycles at q=2 -> q holds 2 for 4 cycles (3 paused + 1 resume), then 3,4,5; no done during pause.
REQ-035 Stop/reset mid-run: stop at q=4 -> next cycle q=0, IDLE, done=0; repeat with rst -> same result.
REQ-036 Boundaries: tc_val=0, mode=1 -> done every cycle, q=0; tc_val=15, N=4 -> q reaches 15, then wraps to 0 with done.
REQ-037 Ignored inputs: start pulsed in RUN and tc_val changed mid-run -> sequence unchanged from original tc_reg.
